// File: rtl/fetch_bundle_queue_pkg.sv
// Shared fetch-packet definitions for the fetch bundle queue: depth, field widths
// and the packed packet layout stored per entry.
package fetch_bundle_queue_pkg;

  localparam int FETCHQ_DEPTH       = 4;
  localparam int SIZE_PC            = 32;
  localparam int FETCH_WIDTH        = 4;
  localparam int INSTRUCTION_BUNDLE = FETCH_WIDTH * 32;

  typedef struct packed {
    logic [SIZE_PC-1:0]             pc;
    logic [INSTRUCTION_BUNDLE-1:0]  bundle;
    logic [FETCH_WIDTH-1:0]         btbHit;
    logic [FETCH_WIDTH-1:0]         pred;
    logic [FETCH_WIDTH*SIZE_PC-1:0] target;
  } fetchPkt_t;

  localparam int FETCH_PKT_W = $bits(fetchPkt_t);

  function automatic fetchPkt_t packFetch(
    input logic [SIZE_PC-1:0]             pc,
    input logic [INSTRUCTION_BUNDLE-1:0]  bundle,
    input logic [FETCH_WIDTH-1:0]         btbHit,
    input logic [FETCH_WIDTH-1:0]         pred,
    input logic [FETCH_WIDTH*SIZE_PC-1:0] target
  );
    fetchPkt_t p;
    p.pc     = pc;
    p.bundle = bundle;
    p.btbHit = btbHit;
    p.pred   = pred;
    p.target = target;
    return p;
  endfunction

endpackage

// File: rtl/fetch_bundle_queue_ram.sv
// fetch_bundle_ram: DEPTH x WIDTH entry storage, one synchronous write port and
// one asynchronous read port. Contents are never reset.
module fetch_bundle_ram
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH,
  parameter int WIDTH = FETCH_PKT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/fetch_bundle_queue.sv
// Circular FIFO between fetch and decode holding fetch packets. Defining
// FETCHQ_BYPASS_EN lets a push into an empty queue appear on the outputs in the same cycle.
module fetch_bundle_queue
  import fetch_bundle_queue_pkg::*;
#(
  parameter int DEPTH     = FETCHQ_DEPTH,
  parameter int AFULL_LVL = DEPTH - 1,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [SIZE_PC-1:0]             pc_i,
  input  logic [INSTRUCTION_BUNDLE-1:0]  bundle_i,
  input  logic [FETCH_WIDTH-1:0]         btbHit_i,
  input  logic [FETCH_WIDTH-1:0]         pred_i,
  input  logic [FETCH_WIDTH*SIZE_PC-1:0] target_i,
  input  logic                           pop_i,
  output logic                           valid_o,
  output logic [SIZE_PC-1:0]             pc_o,
  output logic [INSTRUCTION_BUNDLE-1:0]  bundle_o,
  output logic [FETCH_WIDTH-1:0]         btbHit_o,
  output logic [FETCH_WIDTH-1:0]         pred_o,
  output logic [FETCH_WIDTH*SIZE_PC-1:0] target_o,
  output logic                           full_o,
  output logic                           afull_o,
  output logic [CNT_W-1:0]               count_o
);

  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] count;

  fetchPkt_t inPkt;
  fetchPkt_t headPkt;
  fetchPkt_t outPkt;

  logic empty;
  logic full;
  logic pushAcc;
  logic popAcc;
  logic passThru;
  logic wrEn;
  logic advHead;

  assign inPkt = packFetch(pc_i, bundle_i, btbHit_i, pred_i, target_i);
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
  logic bypassView;
  // An empty queue shows the incoming packet; if it is also popped it never touches storage.
  assign bypassView = empty & push_i;
  assign valid_o    = ~empty | bypassView;
  assign outPkt     = bypassView ? inPkt : headPkt;
  assign passThru   = bypassView & pop_i;
`else
  assign valid_o  = ~empty;
  assign outPkt   = headPkt;
  assign passThru = 1'b0;
`endif

  assign popAcc  = pop_i & valid_o;
  // A full queue still accepts a push when the head is popped on the same edge.
  assign pushAcc = push_i & (~full | pop_i);
  assign wrEn    = pushAcc & ~passThru & ~flush_i;
  assign advHead = popAcc & ~passThru;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (flush_i) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (wrEn) begin
        tailPtr <= tailPtr + 1'b1;
      end
      if (advHead) begin
        headPtr <= headPtr + 1'b1;
      end
      case ({wrEn, advHead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fetch_bundle_ram #(
    .DEPTH(DEPTH),
    .WIDTH(FETCH_PKT_W)
  ) entryRam (
    .clk   (clk),
    .wrEn  (wrEn),
    .wrAddr(tailPtr),
    .wrData(inPkt),
    .rdAddr(headPtr),
    .rdData(headPkt)
  );

  assign pc_o     = outPkt.pc;
  assign bundle_o = outPkt.bundle;
  assign btbHit_o = outPkt.btbHit;
  assign pred_o   = outPkt.pred;
  assign target_o = outPkt.target;

  assign full_o  = full;
  assign afull_o = (count >= CNT_W'(AFULL_LVL));
  assign count_o = count;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Randomised and directed checks of fetch_bundle_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_bundle_queue;
  import fetch_bundle_queue_pkg::*;

  localparam int DEPTH = FETCHQ_DEPTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_i = 1'b0;
  logic push_i = 1'b0;
  logic pop_i = 1'b0;
  logic [SIZE_PC-1:0]             pc_i = '0;
  logic [INSTRUCTION_BUNDLE-1:0]  bundle_i = '0;
  logic [FETCH_WIDTH-1:0]         btbHit_i = '0;
  logic [FETCH_WIDTH-1:0]         pred_i = '0;
  logic [FETCH_WIDTH*SIZE_PC-1:0] target_i = '0;

  logic                           valid_o;
  logic [SIZE_PC-1:0]             pc_o;
  logic [INSTRUCTION_BUNDLE-1:0]  bundle_o;
  logic [FETCH_WIDTH-1:0]         btbHit_o;
  logic [FETCH_WIDTH-1:0]         pred_o;
  logic [FETCH_WIDTH*SIZE_PC-1:0] target_o;
  logic                           full_o;
  logic                           afull_o;
  logic [CNT_W-1:0]               count_o;

  int passCnt = 0;
  int totalCnt = 0;

  fetchPkt_t q[$];
  fetchPkt_t drvPkt;

  always #5 clk = ~clk;

  fetch_bundle_queue #(.DEPTH(DEPTH), .AFULL_LVL(DEPTH - 1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .push_i(push_i),
    .pc_i(pc_i), .bundle_i(bundle_i), .btbHit_i(btbHit_i), .pred_i(pred_i),
    .target_i(target_i), .pop_i(pop_i), .valid_o(valid_o), .pc_o(pc_o),
    .bundle_o(bundle_o), .btbHit_o(btbHit_o), .pred_o(pred_o), .target_o(target_o),
    .full_o(full_o), .afull_o(afull_o), .count_o(count_o)
  );

  function automatic bit expValid();
    bit v;
    v = (q.size() != 0);
`ifdef FETCHQ_BYPASS_EN
    if (q.size() == 0 && push_i) v = 1'b1;
`endif
    return v;
  endfunction

  function automatic fetchPkt_t expHead();
    if (q.size() != 0) return q[0];
    return drvPkt;
  endfunction

  function automatic fetchPkt_t obsPkt();
    return packFetch(pc_o, bundle_o, btbHit_o, pred_o, target_o);
  endfunction

  task automatic drive(input logic push, input logic pop, input logic flush,
                       input logic [SIZE_PC-1:0] pc);
    drvPkt.pc     = pc;
    drvPkt.bundle = INSTRUCTION_BUNDLE'({$urandom, $urandom, $urandom, $urandom});
    drvPkt.btbHit = FETCH_WIDTH'($urandom);
    drvPkt.pred   = FETCH_WIDTH'($urandom);
    drvPkt.target = (FETCH_WIDTH*SIZE_PC)'({$urandom, $urandom, $urandom, $urandom});
    pc_i = drvPkt.pc;  bundle_i = drvPkt.bundle;  btbHit_i = drvPkt.btbHit;
    pred_i = drvPkt.pred;  target_i = drvPkt.target;
    push_i = push;  pop_i = pop;  flush_i = flush;
    #1;
  endtask

  // Advance one clock and apply the queue rules to the reference model.
  task automatic tick();
    bit passThru;
    bit popOk;
    bit pushOk;
    @(posedge clk);
    if (flush_i) begin
      q.delete();
    end else begin
      passThru = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      passThru = (q.size() == 0) && push_i && pop_i;
`endif
      if (!passThru) begin
        popOk  = pop_i && (q.size() > 0);
        pushOk = push_i && ((q.size() < DEPTH) || pop_i);
        if (popOk) void'(q.pop_front());
        if (pushOk) q.push_back(drvPkt);
      end
    end
    #1;
    push_i = 1'b0;  pop_i = 1'b0;  flush_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1 && q.size() != 0; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      tick();
    end
  endtask

  task automatic test_reset();
    totalCnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passCnt++;
    totalCnt++; if (full_o !== 1'b0) $display("FAIL reset_full: got %b want 0", full_o); else passCnt++;
    totalCnt++; if (afull_o !== 1'b0) $display("FAIL reset_afull: got %b want 0", afull_o); else passCnt++;
    totalCnt++; if (count_o !== '0) $display("FAIL reset_count: got %0d want 0", count_o); else passCnt++;
    reset = 1'b0;
    $display("reset released: valid=%b count=%0d", valid_o, count_o);
  endtask

  task automatic test_fill_order();
    logic [SIZE_PC-1:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h120; pcs[2] = 32'h140;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, pcs[i]);
      tick();
      $display("push pc=%h count=%0d", pcs[i], count_o);
    end
    totalCnt++; if (count_o !== CNT_W'(3)) $display("FAIL fill_count: got %0d want 3", count_o); else passCnt++;
    totalCnt++; if (pc_o !== 32'h100) $display("FAIL fill_head_pc: got %h want 100", pc_o); else passCnt++;
    totalCnt++; if (valid_o !== 1'b1) $display("FAIL fill_valid: got %b want 1", valid_o); else passCnt++;
    totalCnt++; if (afull_o !== 1'b1) $display("FAIL fill_afull: got %b want 1", afull_o); else passCnt++;
    totalCnt++; if (full_o !== 1'b0) $display("FAIL fill_full: got %b want 0", full_o); else passCnt++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      totalCnt++; if (pc_o !== pcs[i]) $display("FAIL fill_pop_pc[%0d]: got %h want %h", i, pc_o, pcs[i]); else passCnt++;
      totalCnt++; if (obsPkt() !== q[0]) $display("FAIL fill_pop_pkt[%0d]: got %h want %h", i, obsPkt(), q[0]); else passCnt++;
      $display("pop pc=%h", pc_o);
      tick();
    end
  endtask

  task automatic test_full_drop();
    logic [SIZE_PC-1:0] expOrder [4];
    expOrder[0] = 32'h20; expOrder[1] = 32'h30; expOrder[2] = 32'h40; expOrder[3] = 32'h200;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, SIZE_PC'(i * 'h10));
      tick();
    end
    totalCnt++; if (full_o !== 1'b1) $display("FAIL full_flag: got %b want 1", full_o); else passCnt++;
    drive(1'b1, 1'b0, 1'b0, 32'h200);
    tick();
    $display("push 200 while full, no pop: count=%0d full=%b", count_o, full_o);
    totalCnt++; if (count_o !== CNT_W'(4)) $display("FAIL drop_count: got %0d want 4", count_o); else passCnt++;
    totalCnt++; if (pc_o !== 32'h10) $display("FAIL drop_head: got %h want 10", pc_o); else passCnt++;
    drive(1'b1, 1'b1, 1'b0, 32'h200);
    tick();
    $display("push 200 while full, with pop: count=%0d", count_o);
    totalCnt++; if (count_o !== CNT_W'(4)) $display("FAIL reuse_count: got %0d want 4", count_o); else passCnt++;
    totalCnt++; if (full_o !== 1'b1) $display("FAIL reuse_full: got %b want 1", full_o); else passCnt++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      totalCnt++; if (pc_o !== expOrder[i]) $display("FAIL full_pop_pc[%0d]: got %h want %h", i, pc_o, expOrder[i]); else passCnt++;
      tick();
    end
    totalCnt++; if (count_o !== '0) $display("FAIL full_drain_count: got %0d want 0", count_o); else passCnt++;
  endtask

  task automatic test_wrap();
    logic [SIZE_PC-1:0] expPc;
    drive(1'b1, 1'b0, 1'b0, 32'h400);
    tick();
    for (int i = 0; i < 10; i++) begin
      expPc = (i == 0) ? 32'h400 : SIZE_PC'(32'h500 + (i - 1) * 'h10);
      drive(1'b1, 1'b1, 1'b0, SIZE_PC'(32'h500 + i * 'h10));
      totalCnt++; if (pc_o !== expPc) $display("FAIL wrap_pc[%0d]: got %h want %h", i, pc_o, expPc); else passCnt++;
      tick();
      totalCnt++; if (count_o !== CNT_W'(1)) $display("FAIL wrap_count[%0d]: got %0d want 1", i, count_o); else passCnt++;
      $display("wrap pair %0d: out pc=%h count=%0d", i, expPc, count_o);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, SIZE_PC'(32'h600 + i * 'h10));
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h6F0);
    tick();
    $display("flush with push+pop: count=%0d valid=%b", count_o, valid_o);
    totalCnt++; if (count_o !== '0) $display("FAIL flush_count: got %0d want 0", count_o); else passCnt++;
    totalCnt++; if (valid_o !== 1'b0) $display("FAIL flush_valid: got %b want 0", valid_o); else passCnt++;
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    totalCnt++; if (valid_o !== 1'b0) $display("FAIL flush_ghost: got valid=%b pc=%h want 0", valid_o, pc_o); else passCnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, SIZE_PC'(32'h700 + i * 'h10));
      tick();
    end
    totalCnt++; if (count_o !== CNT_W'(2)) $display("FAIL areset_pre_count: got %0d want 2", count_o); else passCnt++;
    #2;
    reset = 1'b1;
    #1;
    $display("async reset mid-cycle: valid=%b count=%0d", valid_o, count_o);
    totalCnt++; if (valid_o !== 1'b0) $display("FAIL areset_valid: got %b want 0", valid_o); else passCnt++;
    totalCnt++; if (count_o !== '0) $display("FAIL areset_count: got %0d want 0", count_o); else passCnt++;
    q.delete();
    #3;
    reset = 1'b0;
  endtask

  task automatic test_bypass();
`ifdef FETCHQ_BYPASS_EN
    drive(1'b1, 1'b1, 1'b0, 32'h300);
    $display("bypass push+pop 300: valid=%b pc=%h count=%0d", valid_o, pc_o, count_o);
    totalCnt++; if (valid_o !== 1'b1) $display("FAIL bypass_valid: got %b want 1", valid_o); else passCnt++;
    totalCnt++; if (pc_o !== 32'h300) $display("FAIL bypass_pc: got %h want 300", pc_o); else passCnt++;
    tick();
    totalCnt++; if (count_o !== '0) $display("FAIL bypass_count: got %0d want 0", count_o); else passCnt++;
    drive(1'b1, 1'b0, 1'b0, 32'h310);
    totalCnt++; if (valid_o !== 1'b1) $display("FAIL bypass_nopop_valid: got %b want 1", valid_o); else passCnt++;
    tick();
    totalCnt++; if (count_o !== CNT_W'(1)) $display("FAIL bypass_nopop_count: got %0d want 1", count_o); else passCnt++;
    totalCnt++; if (pc_o !== 32'h310) $display("FAIL bypass_nopop_pc: got %h want 310", pc_o); else passCnt++;
`else
    drive(1'b1, 1'b1, 1'b0, 32'h300);
    $display("push+pop 300 into empty: valid=%b count=%0d", valid_o, count_o);
    totalCnt++; if (valid_o !== 1'b0) $display("FAIL latency_valid: got %b want 0", valid_o); else passCnt++;
    tick();
    totalCnt++; if (count_o !== CNT_W'(1)) $display("FAIL latency_count: got %0d want 1", count_o); else passCnt++;
    totalCnt++; if (pc_o !== 32'h300) $display("FAIL latency_pc: got %h want 300", pc_o); else passCnt++;
`endif
    drain();
  endtask

  task automatic test_random();
    bit pu;
    bit po;
    bit fl;
    for (int n = 0; n < 400; n++) begin
      pu = ($urandom_range(0, 99) < 65);
      po = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 99) < 3);
      drive(pu, po, fl, $urandom);
      totalCnt++; if (valid_o !== expValid()) $display("FAIL rand_valid[%0d]: got %b want %b", n, valid_o, expValid()); else passCnt++;
      totalCnt++; if (count_o !== CNT_W'(q.size())) $display("FAIL rand_count[%0d]: got %0d want %0d", n, count_o, q.size()); else passCnt++;
      totalCnt++; if (full_o !== (q.size() == DEPTH)) $display("FAIL rand_full[%0d]: got %b want %b", n, full_o, q.size() == DEPTH); else passCnt++;
      totalCnt++; if (afull_o !== (q.size() >= DEPTH - 1)) $display("FAIL rand_afull[%0d]: got %b want %b", n, afull_o, q.size() >= DEPTH - 1); else passCnt++;
      if (expValid()) begin
        totalCnt++; if (obsPkt() !== expHead()) $display("FAIL rand_head[%0d]: got pc=%h want pc=%h", n, pc_o, expHead().pc); else passCnt++;
      end
      $display("rand %0d: push=%b pop=%b flush=%b count=%0d valid=%b pc=%h", n, pu, po, fl, count_o, valid_o, pc_o);
      tick();
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_fill_order();
    test_full_drop();
    test_wrap();
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
